// File: rtl/scr1_dmem_tgt_ram_pkg.sv
// Shared dmem interface types and widths for the dmem target RAM.
// Mirrors the command/width/response encodings of the SCR1 memory interface.
package scr1_dmem_tgt_ram_pkg;

    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'd0,
        SCR1_MEM_CMD_WR    = 2'd1,
        SCR1_MEM_CMD_ERROR = 2'd2
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'd0,
        SCR1_MEM_WIDTH_HWORD = 2'd1,
        SCR1_MEM_WIDTH_WORD  = 2'd2,
        SCR1_MEM_WIDTH_ERROR = 2'd3
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'd0,
        SCR1_MEM_RESP_RDY_OK = 2'd1,
        SCR1_MEM_RESP_RDY_ER = 2'd2
    } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_dmem_tgt_ram_array.sv
// Byte-lane RAM for the dmem target: one 8-bit array per lane, shared address,
// synchronous read register that only updates on a read strobe.
module scr1_dmem_tgt_array #(
    parameter int WORDS = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic [3:0]       i_we,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [WORDS];
            logic [7:0] r_rd;

            always_ff @(posedge clk) begin
                if (i_we[gi]) begin
                    r_mem[i_addr] <= i_wdata[gi*8 +: 8];
                end
                if (i_re) begin
                    r_rd <= r_mem[i_addr];
                end
            end

            assign o_rdata[gi*8 +: 8] = r_rd;
        end
    endgenerate

endmodule

// File: rtl/scr1_dmem_tgt_ram.sv
// dmem router target: scratchpad RAM with byte-lane writes and error detection.
// Define SCR1_DMEM_TGT_WAIT_EN to build the programmable wait-state counter.
module scr1_dmem_tgt_ram
    import scr1_dmem_tgt_ram_pkg::*;
#(
    parameter int SCR1_TGT_WORDS = 256,
    parameter int SCR1_TGT_WAIT  = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        dmem_req_ack,
    input  logic                        dmem_req,
    input  type_scr1_mem_cmd_e          dmem_cmd,
    input  type_scr1_mem_width_e        dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
    output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
    output type_scr1_mem_resp_e         dmem_resp
);

    localparam int IDX_W = $clog2(SCR1_TGT_WORDS);
    localparam int DEC_W = IDX_W + 2;

    localparam logic [3:0] BE_BYTE0    = 4'b0001;
    localparam logic [3:0] BE_HWORD_LO = 4'b0011;
    localparam logic [3:0] BE_HWORD_HI = 4'b1100;
    localparam logic [3:0] BE_WORD     = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } type_fsm_e;

    if ((SCR1_TGT_WORDS & (SCR1_TGT_WORDS - 1)) != 0 || SCR1_TGT_WORDS < 4 ||
        SCR1_TGT_WORDS > 4096 || SCR1_TGT_WAIT < 0 || SCR1_TGT_WAIT > 15) begin : g_bad_cfg
        $error("scr1_dmem_tgt_ram: unsupported WORDS/WAIT configuration");
    end

    type_fsm_e           r_state;
    type_scr1_mem_resp_e r_resp;
    logic                r_rd_ok;

    logic                w_accept;
    logic                w_err;
    logic                w_is_rd;
    logic                w_is_wr;
    logic [3:0]          w_be;
    logic [3:0]          w_we;
    logic                w_re;
    logic [31:0]         w_arr_rdata;

`ifdef SCR1_DMEM_TGT_WAIT_EN
    localparam logic [3:0] WAIT_INIT = 4'(SCR1_TGT_WAIT);
    logic [3:0] r_cnt;
    logic       r_err;
    logic       r_cmd_rd;
`endif

    // Ack depends on FSM state only, so the router never sees a comb loop.
    assign dmem_req_ack = (r_state == ST_IDLE) || (r_state == ST_RESP);
    assign w_accept     = dmem_req & dmem_req_ack;
    assign w_is_rd      = (dmem_cmd == SCR1_MEM_CMD_RD);
    assign w_is_wr      = (dmem_cmd == SCR1_MEM_CMD_WR);

    always_comb begin
        w_be  = 4'b0000;
        w_err = 1'b0;
        case (dmem_width)
            SCR1_MEM_WIDTH_BYTE: begin
                w_be = BE_BYTE0 << dmem_addr[1:0];
            end
            SCR1_MEM_WIDTH_HWORD: begin
                w_be  = dmem_addr[1] ? BE_HWORD_HI : BE_HWORD_LO;
                w_err = dmem_addr[0];
            end
            SCR1_MEM_WIDTH_WORD: begin
                w_be  = BE_WORD;
                w_err = |dmem_addr[1:0];
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
        if (!(w_is_rd || w_is_wr)) begin
            w_err = 1'b1;
        end
        if (|dmem_addr[SCR1_DMEM_AWIDTH-1:DEC_W]) begin
            w_err = 1'b1;
        end
    end

    // Writes commit and reads sample on the accept edge itself.
    assign w_we = (w_accept && w_is_wr && !w_err) ? w_be : 4'b0000;
    assign w_re = w_accept && w_is_rd && !w_err;

    scr1_dmem_tgt_array #(
        .WORDS (SCR1_TGT_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (dmem_addr[DEC_W-1:2]),
        .i_wdata (dmem_wdata),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_resp   <= SCR1_MEM_RESP_NOTRDY;
            r_rd_ok  <= 1'b0;
`ifdef SCR1_DMEM_TGT_WAIT_EN
            r_cnt    <= 4'd0;
            r_err    <= 1'b0;
            r_cmd_rd <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_accept) begin
`ifdef SCR1_DMEM_TGT_WAIT_EN
                        r_err    <= w_err;
                        r_cmd_rd <= w_is_rd;
                        if (WAIT_INIT != 4'd0) begin
                            r_cnt   <= WAIT_INIT;
                            r_state <= ST_WAIT;
                            r_resp  <= SCR1_MEM_RESP_NOTRDY;
                            r_rd_ok <= 1'b0;
                        end else begin
                            r_state <= ST_RESP;
                            r_resp  <= w_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                            r_rd_ok <= w_is_rd && !w_err;
                        end
`else
                        r_state <= ST_RESP;
                        r_resp  <= w_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                        r_rd_ok <= w_is_rd && !w_err;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                        r_resp  <= SCR1_MEM_RESP_NOTRDY;
                        r_rd_ok <= 1'b0;
                    end
                end
`ifdef SCR1_DMEM_TGT_WAIT_EN
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_RESP;
                        r_resp  <= r_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                        r_rd_ok <= r_cmd_rd && !r_err;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_resp  <= SCR1_MEM_RESP_NOTRDY;
                    r_rd_ok <= 1'b0;
                end
            endcase
        end
    end

    // The array read register is held between reads; gating keeps rdata 0 off RDY_OK reads.
    assign dmem_resp  = r_resp;
    assign dmem_rdata = r_rd_ok ? w_arr_rdata : '0;

`ifndef SYNTHESIS
    a_no_x_ctrl : assert property (@(posedge clk) disable iff (!rst_n)
        dmem_req |-> !$isunknown({dmem_cmd, dmem_width}));

    a_resp_once : assert property (@(posedge clk) disable iff (!rst_n)
        (dmem_resp != SCR1_MEM_RESP_NOTRDY) |=>
            ((dmem_resp == SCR1_MEM_RESP_NOTRDY) || $past(w_accept)));
`endif

endmodule

// File: tb/tb_scr1_dmem_tgt_ram.sv
// Directed bench for scr1_dmem_tgt_ram; expected latency follows SCR1_DMEM_TGT_WAIT_EN
// (WAIT=3 when defined, otherwise a fixed single-cycle response).
module tb_scr1_dmem_tgt_ram;
    import scr1_dmem_tgt_ram_pkg::*;

`ifdef SCR1_DMEM_TGT_WAIT_EN
    localparam int TB_WAIT = 3;
`else
    localparam int TB_WAIT = 0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 req;
    logic                 ack;
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    type_scr1_mem_resp_e  resp;

    int n_checks = 0;
    int n_errors = 0;

    scr1_dmem_tgt_ram #(
        .SCR1_TGT_WORDS (256),
        .SCR1_TGT_WAIT  (TB_WAIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_req_ack (ack),
        .dmem_req     (req),
        .dmem_cmd     (cmd),
        .dmem_width   (width),
        .dmem_addr    (addr),
        .dmem_wdata   (wdata),
        .dmem_rdata   (rdata),
        .dmem_resp    (resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                         input logic [31:0] a, input logic [31:0] d);
        req   = 1'b1;
        cmd   = c;
        width = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic busy_cycles(input string tag);
        repeat (TB_WAIT) begin
            @(negedge clk);
            chk({tag, "_busy"}, {29'd0, ack, resp}, {29'd0, 1'b0, SCR1_MEM_RESP_NOTRDY});
        end
    endtask

    // Entered just after a posedge with the FSM idle; leaves just after a posedge.
    task automatic single(input string tag, input type_scr1_mem_cmd_e c,
                          input type_scr1_mem_width_e w, input logic [31:0] a,
                          input logic [31:0] d, input type_scr1_mem_resp_e exp_resp,
                          input logic [31:0] exp_rdata);
        drive(c, w, a, d);
        @(negedge clk);
        chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
        @(posedge clk);
        #1 req = 1'b0;
        busy_cycles(tag);
        @(negedge clk);
        chk({tag, "_resp"}, {30'd0, resp}, {30'd0, exp_resp});
        chk({tag, "_rdata"}, rdata, exp_rdata);
        $display("txn %s addr=%h resp=%0d rdata=%h", tag, a, resp, rdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_ack", {31'd0, ack}, 32'd1);
            chk("rst_resp", {30'd0, resp}, {30'd0, SCR1_MEM_RESP_NOTRDY});
            chk("rst_rdata", rdata, 32'h0);
        end
        $display("txn reset_idle ack=%0d resp=%0d rdata=%h", ack, resp, rdata);
        @(posedge clk);
        #1;

        // Back-to-back WR then RD of the same word.
        drive(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'hDEADBEEF);
        @(posedge clk);
        #1 drive(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);
        busy_cycles("b2b_wr");
        @(negedge clk);
        chk("b2b_wr_resp", {30'd0, resp}, {30'd0, SCR1_MEM_RESP_RDY_OK});
        chk("b2b_wr_ack", {31'd0, ack}, 32'd1);
        chk("b2b_wr_rdata", rdata, 32'h0);
        $display("txn b2b_wr addr=00000010 resp=%0d rdata=%h", resp, rdata);
        @(posedge clk);
        #1 req = 1'b0;
        busy_cycles("b2b_rd");
        @(negedge clk);
        chk("b2b_rd_resp", {30'd0, resp}, {30'd0, SCR1_MEM_RESP_RDY_OK});
        chk("b2b_rd_rdata", rdata, 32'hDEADBEEF);
        $display("txn b2b_rd addr=00000010 resp=%0d rdata=%h", resp, rdata);
        @(posedge clk);
        #1;

        // Lane writes with junk in the unselected lanes.
        single("wr_byte3", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h13, 32'h55A5A5A5,
               SCR1_MEM_RESP_RDY_OK, 32'h0);
        single("wr_hw0", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h10, 32'hFFFF1234,
               SCR1_MEM_RESP_RDY_OK, 32'h0);
        single("rd_lanes", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'h55AD1234);

        // Error cases must not touch word 0x10.
        single("er_hw_odd", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h11, 32'h0,
               SCR1_MEM_RESP_RDY_ER, 32'h0);
        single("er_wd_mis", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h12, 32'h0,
               SCR1_MEM_RESP_RDY_ER, 32'h0);
        single("er_range", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h400, 32'h0,
               SCR1_MEM_RESP_RDY_ER, 32'h0);
        single("er_range_wr", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h410, 32'h0,
               SCR1_MEM_RESP_RDY_ER, 32'h0);
        single("er_width", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_ERROR, 32'h10, 32'h0,
               SCR1_MEM_RESP_RDY_ER, 32'h0);
        single("er_cmd", SCR1_MEM_CMD_ERROR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0,
               SCR1_MEM_RESP_RDY_ER, 32'h0);
        single("rd_after_er", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'h55AD1234);

        // Top word of the decoded range, upper-halfword and top-byte lanes.
        single("wr_top", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h3FC, 32'h11223344,
               SCR1_MEM_RESP_RDY_OK, 32'h0);
        single("wr_top_b3", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h3FF, 32'hAB000000,
               SCR1_MEM_RESP_RDY_OK, 32'h0);
        single("wr_top_hw1", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h3FE, 32'hCD77FFFF,
               SCR1_MEM_RESP_RDY_OK, 32'h0);
        single("rd_top", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h3FC, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'hCD773344);
        single("rd_w0_intact", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'h55AD1234);

        // Reset while a read is pending.
        drive(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);
        @(posedge clk);
        #1 req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp", {30'd0, resp}, {30'd0, SCR1_MEM_RESP_NOTRDY});
        chk("mid_rst_ack", {31'd0, ack}, 32'd1);
        chk("mid_rst_rdata", rdata, 32'h0);
        $display("txn mid_reset resp=%0d ack=%0d rdata=%h", resp, ack, rdata);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        single("post_rst_rd", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'h55AD1234);
        single("post_rst_idle", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h3FD, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'hCD773344);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
